// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the convolution input cache.
package conv_pkg;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned KERNEL_SIZE = 3;
    localparam int unsigned IMAGE_SIZE  = 8;
    localparam int unsigned ARRAY_SIZE  = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int unsigned TAPS        = KERNEL_SIZE * KERNEL_SIZE;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StFill,
        StEmit,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/conv_input_cache_if.sv
// Weight/pixel input handshake and lane-bus output of the convolution input cache.
interface conv_input_cache_if #(
    parameter int unsigned WIDTH      = conv_pkg::WIDTH,
    parameter int unsigned ARRAY_SIZE = conv_pkg::ARRAY_SIZE
);
    logic                        i_start;
    logic [WIDTH-1:0]            i_weight;
    logic                        i_weight_valid;
    logic [WIDTH-1:0]            i_pixel;
    logic                        i_pixel_valid;
    logic                        o_pixel_ready;
    logic [ARRAY_SIZE*WIDTH-1:0] o_pixel_bus;
    logic [WIDTH-1:0]            o_weight;
    logic                        o_valid;
    logic                        o_busy;
    logic                        o_done;

    modport slave (
        input  i_start, i_weight, i_weight_valid, i_pixel, i_pixel_valid,
        output o_pixel_ready, o_pixel_bus, o_weight, o_valid, o_busy, o_done
    );

    modport master (
        output i_start, i_weight, i_weight_valid, i_pixel, i_pixel_valid,
        input  o_pixel_ready, o_pixel_bus, o_weight, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/conv_line_buffer.sv
// Three image line rows plus a staging row; a shift retires the oldest row in one step.
module conv_line_buffer #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned IMAGE_SIZE  = 8,
    parameter int unsigned ARRAY_SIZE  = 6,
    localparam int unsigned RowW       = $clog2(KERNEL_SIZE),
    localparam int unsigned ColW       = $clog2(IMAGE_SIZE)
) (
    input  logic                        clk,
    input  logic                        line_we,
    input  logic                        stage_we,
    input  logic                        shift_en,
    input  logic [RowW-1:0]             wr_row,
    input  logic [ColW-1:0]             wr_col,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [RowW-1:0]             rd_row,
    input  logic [RowW-1:0]             rd_col,
    output logic [ARRAY_SIZE*WIDTH-1:0] window
);
    logic [WIDTH-1:0] line_q  [KERNEL_SIZE][IMAGE_SIZE];
    logic [WIDTH-1:0] stage_q [IMAGE_SIZE];

    always_ff @(posedge clk) begin
        if (line_we) line_q[wr_row][wr_col] <= wr_data;
        if (stage_we) stage_q[wr_col] <= wr_data;
        if (shift_en) begin
            for (int r = 0; r < KERNEL_SIZE - 1; r++) line_q[r] <= line_q[r+1];
            // The final pixel of the row arrives on the shift cycle itself.
            for (int c = 0; c < IMAGE_SIZE; c++) begin
                line_q[KERNEL_SIZE-1][c] <= (ColW'(c) == wr_col) ? wr_data : stage_q[c];
            end
        end
    end

    always_comb begin
        window = '0;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            window[(ARRAY_SIZE-1-j)*WIDTH +: WIDTH] = line_q[rd_row][ColW'(j) + ColW'(rd_col)];
        end
    end
endmodule

// File: rtl/conv_input_cache.sv
// Frame sequencer: loads kernel weights, streams image rows and emits one tap per cycle.
module conv_input_cache #(
    parameter int unsigned WIDTH       = conv_pkg::WIDTH,
    parameter int unsigned KERNEL_SIZE = conv_pkg::KERNEL_SIZE,
    parameter int unsigned IMAGE_SIZE  = conv_pkg::IMAGE_SIZE,
    parameter int unsigned ARRAY_SIZE  = conv_pkg::ARRAY_SIZE
) (
    input logic               clk,
    input logic               rst_n,
    conv_input_cache_if.slave bus
);
    import conv_pkg::*;

    localparam int unsigned Taps = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned RowW = $clog2(KERNEL_SIZE);
    localparam int unsigned ColW = $clog2(IMAGE_SIZE);
    localparam int unsigned OutW = $clog2(ARRAY_SIZE);
    localparam int unsigned TapW = $clog2(Taps);

    state_e                      state_q, state_d;
    logic [TapW-1:0]             wcnt_q, wcnt_d, tap_q, tap_d, ld_tap;
    logic [RowW-1:0]             lrow_q, lrow_d, rd_row, rd_col;
    logic [ColW-1:0]             col_q, col_d;
    logic [OutW-1:0]             orow_q, orow_d;
    logic [WIDTH-1:0]            w_q [Taps];
    logic                        ld_out, row_off, w_we, line_we, stage_we, shift_en, pix_acc;
    logic [ARRAY_SIZE*WIDTH-1:0] window;

    assign pix_acc = bus.i_pixel_valid && bus.o_pixel_ready;
    // On the SHIFT->EMIT step the rows have not moved yet, so tap 0 reads the future L0.
    assign rd_row  = RowW'(32'(ld_tap) / KERNEL_SIZE) + RowW'(row_off);
    assign rd_col  = RowW'(32'(ld_tap) % KERNEL_SIZE);

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        tap_d    = tap_q;
        lrow_d   = lrow_q;
        col_d    = col_q;
        orow_d   = orow_q;
        ld_out   = 1'b0;
        ld_tap   = '0;
        row_off  = 1'b0;
        w_we     = 1'b0;
        line_we  = 1'b0;
        stage_we = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            StIdle: if (bus.i_start) begin
                state_d = StLoadW;
                wcnt_d  = '0;
                tap_d   = '0;
                lrow_d  = '0;
                col_d   = '0;
                orow_d  = '0;
            end
            StLoadW: if (bus.i_weight_valid) begin
                w_we = 1'b1;
                if (wcnt_q == TapW'(Taps - 1)) begin
                    wcnt_d  = '0;
                    state_d = StFill;
                end else wcnt_d = wcnt_q + 1'b1;
            end
            StFill: if (pix_acc) begin
                line_we = 1'b1;
                if (col_q == ColW'(IMAGE_SIZE - 1)) begin
                    col_d = '0;
                    if (lrow_q == RowW'(KERNEL_SIZE - 1)) begin
                        lrow_d  = '0;
                        state_d = StEmit;
                        ld_out  = 1'b1;
                    end else lrow_d = lrow_q + 1'b1;
                end else col_d = col_q + 1'b1;
            end
            StEmit: if (tap_q == TapW'(Taps - 1)) begin
                tap_d   = '0;
                state_d = (orow_q == OutW'(ARRAY_SIZE - 1)) ? StDone : StShift;
            end else begin
                tap_d  = tap_q + 1'b1;
                ld_out = 1'b1;
                ld_tap = tap_d;
            end
            StShift: if (pix_acc) begin
                stage_we = 1'b1;
                if (col_q == ColW'(IMAGE_SIZE - 1)) begin
                    col_d    = '0;
                    shift_en = 1'b1;
                    orow_d   = orow_q + 1'b1;
                    state_d  = StEmit;
                    ld_out   = 1'b1;
                    row_off  = 1'b1;
                end else col_d = col_q + 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            tap_q   <= '0;
            lrow_q  <= '0;
            col_q   <= '0;
            orow_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tap_q   <= tap_d;
            lrow_q  <= lrow_d;
            col_q   <= col_d;
            orow_q  <= orow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) w_q[wcnt_q] <= bus.i_weight;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_valid       <= 1'b0;
            bus.o_busy        <= 1'b0;
            bus.o_done        <= 1'b0;
            bus.o_pixel_ready <= 1'b0;
            bus.o_pixel_bus   <= '0;
            bus.o_weight      <= '0;
        end else begin
            bus.o_valid       <= ld_out;
            bus.o_busy        <= (state_d != StIdle);
            bus.o_done        <= (state_d == StDone);
            bus.o_pixel_ready <= (state_d == StFill) || (state_d == StShift);
            if (ld_out) begin
                bus.o_pixel_bus <= window;
                bus.o_weight    <= w_q[ld_tap];
            end
        end
    end

    conv_line_buffer #(
        .WIDTH      (WIDTH),
        .KERNEL_SIZE(KERNEL_SIZE),
        .IMAGE_SIZE (IMAGE_SIZE),
        .ARRAY_SIZE (ARRAY_SIZE)
    ) u_line_buffer (
        .clk     (clk),
        .line_we (line_we),
        .stage_we(stage_we),
        .shift_en(shift_en),
        .wr_row  (lrow_q),
        .wr_col  (col_q),
        .wr_data (bus.i_pixel),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .window  (window)
    );
endmodule

// File: doc/conv_input_cache.md
CONV_INPUT_CACHE -- requirements
Module: conv_input_cache

Interface
REQ-001 Parameter WIDTH, default 32: bit width of one pixel and of one weight.
REQ-002 Parameter KERNEL_SIZE, default 3: kernel edge length; the kernel has 9 taps.
REQ-003 Parameter IMAGE_SIZE, default 8: input image edge length.
REQ-004 Parameter ARRAY_SIZE, default 6: number of outputs per row, equal to IMAGE_SIZE-KERNEL_SIZE+1.
REQ-005 clk  in  1: the single clock; all logic SHALL be on the rising edge.
REQ-006 rst_n  in  1: asynchronous, active-low reset.
REQ-007 i_start  in  1: single-cycle frame start request.
REQ-008 i_weight  in  WIDTH: kernel weight data.
REQ-009 i_weight_valid  in  1: i_weight carries a valid weight this cycle.
REQ-010 i_pixel  in  WIDTH: image pixel data, delivered row-major.
REQ-011 i_pixel_valid  in  1: i_pixel carries a valid pixel this cycle.
REQ-012 o_pixel_ready  out  1: the block accepts a pixel this cycle.
REQ-013 o_pixel_bus  out  ARRAY_SIZE*WIDTH: one pixel per array lane; lane 0 occupies the MSBs.
REQ-014 o_weight  out  WIDTH: weight broadcast to all lanes.
REQ-015 o_valid  out  1: o_pixel_bus and o_weight are valid this cycle.
REQ-016 o_busy  out  1: a frame is in progress (high in every state except IDLE).
REQ-017 o_done  out  1: one-cycle pulse at frame end.

Function
REQ-018 States: IDLE, LOAD_W, FILL, EMIT, SHIFT, DONE.
REQ-019 IDLE: i_start SHALL move to LOAD_W; i_start in any other state SHALL be ignored.
REQ-020 LOAD_W: the block SHALL store 9 weights w[0..8] (row-major taps), one per cycle with i_weight_valid high, then go to FILL; i_weight_valid outside LOAD_W SHALL be ignored.
REQ-021 Pixel acceptance: a pixel SHALL be accepted only when i_pixel_valid and o_pixel_ready are both high; o_pixel_ready SHALL be high only in FILL and SHIFT.
REQ-022 FILL: the block SHALL accept KERNEL_SIZE*IMAGE_SIZE pixels (24) into line rows L0..L2, then go to EMIT.
REQ-023 EMIT: the block SHALL run 9 cycles with o_valid high; for tap k, kr=k/3 and kc=k%3, lane j SHALL equal L[kr][j+kc] and o_weight SHALL equal w[k]. There is no backpressure.
REQ-024 After the 9th EMIT cycle the block SHALL go to DONE if the output row counter equals ARRAY_SIZE-1, otherwise to SHIFT.
REQ-025 SHIFT: the block SHALL accept IMAGE_SIZE pixels into a staging row, then in one step set L0<=L1, L1<=L2, L2<=staging, increment the output row counter, and go to EMIT. L0..L2 SHALL NOT change while a row is partially received.
REQ-026 DONE: o_done SHALL be high for exactly one cycle, then the block SHALL return to IDLE.
REQ-027 Outputs SHALL be registered. The first o_valid SHALL occur the cycle after the 24th pixel is accepted.
REQ-028 Totals per frame: 64 pixels accepted, 54 o_valid cycles, one o_done.
REQ-029 Outside EMIT, o_valid SHALL be 0; o_pixel_bus and o_weight SHALL hold their last values.
REQ-030 Gaps in i_pixel_valid or i_weight_valid SHALL stall only the relevant counter and SHALL NOT alter the output sequence.

Reset
REQ-031 On rst_n low, immediately and regardless of state: state SHALL be IDLE, all counters 0, and o_pixel_bus, o_weight, o_valid, o_pixel_ready, o_busy and o_done SHALL be 0.
REQ-032 Reset mid-frame SHALL abandon the frame. Weight and line storage need not be cleared.

Structure
REQ-033 A shared package conv_pkg SHALL hold WIDTH, KERNEL_SIZE, IMAGE_SIZE, ARRAY_SIZE and the state enumeration.
REQ-034 One sub-module, conv_line_buffer, SHALL hold L0..L2, the staging row and the shift operation; the FSM and counters stay in conv_input_cache.

Verification
REQ-035 Full frame: weights 1..9 and pixel p=r*8+c -> 1st valid cycle bus {0,1,2,3,4,5} with weight 1; 5th valid cycle bus {9..14} with weight 5; 54 valid cycles; 1 o_done.
REQ-036 Last tap: row 5, k=8 -> bus {58..63} with weight 9, then o_done on the next cycle.
REQ-037 i_pixel_valid toggled every other cycle -> valid-cycle data identical to REQ-035; 64 pixels accepted; o_pixel_ready low during EMIT.
REQ-038 rst_n low during row 2, tap 3 -> all outputs 0 at once; after release, i_start runs a clean frame matching REQ-035.
REQ-039 i_start during EMIT and i_weight_valid during FILL -> no effect on the sequence or the weights.
